// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / hazard unit.
package fwd_pkg;

    // Shadow entries store rd at a fixed width; REG_AW must not exceed it.
    localparam int SB_RD_W      = 8;
    localparam int SB_MAX_DEPTH = 16;

    // Operand select encoding: 0 = register file, k = pipeline register after stage k.
    localparam int SEL_RF    = 0;
    localparam int SEL_EXMEM = 1;
    localparam int SEL_MEMWB = 2;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               regwr;
        logic               is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Smallest stage index whose hit bit is set (youngest producer); 0 when none.
    function automatic logic [4:0] youngest_match(input logic [SB_MAX_DEPTH:1] hits);
        logic [4:0] idx;
        idx = '0;
        for (int k = SB_MAX_DEPTH; k >= 1; k--) begin
            if (hits[k]) idx = 5'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// One source operand checked against every in-flight shadow entry.
module fwd_src_match
    import fwd_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_READY = 2,
    parameter int SELW       = 2
) (
    input  logic [REG_AW-1:0] src_addr,
    input  logic              src_used,
    input  logic              is_branch,
    input  sb_entry_t         ent [1:DEPTH],
    output logic [SELW-1:0]   match_stage,
    output logic              hazard
);

    logic [SB_MAX_DEPTH:1] hits;
    logic [4:0]            jm;
    logic                  prod_load;
    int                    need;

    // Youngest matching producer and whether its data is still too far away.
    always_comb begin
        hits = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            hits[k] = src_used & ent[k].valid & ent[k].regwr
                    & (ent[k].rd != '0)
                    & (ent[k].rd == SB_RD_W'(src_addr));
        end
        jm = youngest_match(hits);
        prod_load = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (int'(jm) == k) prod_load = ent[k].is_load;
        end
        // A branch consumes its sources one stage earlier than EX does.
        need        = (prod_load ? LOAD_READY : 1) + (is_branch ? 1 : 0);
        match_stage = SELW'(jm);
        hazard      = (jm != '0) && (int'(jm) < need);
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use / branch stall generator with a shadow
// pipeline of in-flight destination registers. e[k] is the instruction k
// stages past ID. A producer in e[j] has its result in the register after
// stage j-1 right now (ID comparator select j-1) and in the register after
// stage j one cycle later, when the consumer is in EX (EX select j). Once
// j reaches DEPTH the register file has been written, so EX uses select 0.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 3,
    parameter int REG_AW     = 5,
    parameter int LOAD_READY = 2,
    parameter int SELW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dst_addr,
    input  logic                      id_regwr,
    input  logic                      id_is_load,
    input  logic                      id_is_branch,
    input  logic                      ext_stall,
    input  logic                      flush,
    output logic                      stall_req,
    output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel,
    output logic [NUM_SRC*SELW-1:0]   id_cmp_sel,
    output logic [31:0]               stall_count
);

    sb_entry_t                 sb_q [1:DEPTH];
    sb_entry_t                 sb_d [1:DEPTH];
    logic [NUM_SRC*SELW-1:0]   ex_fwd_sel_q, ex_fwd_sel_d, ex_sel_next;
    logic [31:0]               stall_count_q, stall_count_d;
    logic [NUM_SRC-1:0]        src_hazard;
    logic [SELW-1:0]           src_stage [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        fwd_src_match #(
            .DEPTH      (DEPTH),
            .REG_AW     (REG_AW),
            .LOAD_READY (LOAD_READY),
            .SELW       (SELW)
        ) u_match (
            .src_addr    (id_src_addr[g*REG_AW +: REG_AW]),
            .src_used    (id_src_used[g]),
            .is_branch   (id_is_branch),
            .ent         (sb_q),
            .match_stage (src_stage[g]),
            .hazard      (src_hazard[g])
        );
    end

    assign stall_req   = id_valid & ~flush & (|src_hazard);
    assign ex_fwd_sel  = ex_fwd_sel_q;
    assign stall_count = stall_count_q;

    // Map youngest-producer stage to ID comparator and next-EX selects.
    always_comb begin
        ex_sel_next = '0;
        id_cmp_sel  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_stage[i] <= SELW'(DEPTH - 1))
                ex_sel_next[i*SELW +: SELW] = src_stage[i];
            else
                ex_sel_next[i*SELW +: SELW] = SELW'(SEL_RF);
            if (src_stage[i] != '0)
                id_cmp_sel[i*SELW +: SELW] = src_stage[i] - SELW'(1);
        end
    end

    // Shadow pipeline advance, EX select capture and stall counting.
    always_comb begin
        sb_d          = sb_q;
        ex_fwd_sel_d  = ex_fwd_sel_q;
        stall_count_d = stall_count_q;
        if (!ext_stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            if (flush || stall_req) begin
                sb_d[1]      = SB_BUBBLE;
                ex_fwd_sel_d = '0;
                if (stall_req && (stall_count_q != '1))
                    stall_count_d = stall_count_q + 32'd1;
            end else begin
                sb_d[1] = '{valid:   id_valid,
                            rd:      SB_RD_W'(id_dst_addr),
                            regwr:   id_regwr,
                            is_load: id_is_load};
                ex_fwd_sel_d = ex_sel_next;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) sb_q[k] <= SB_BUBBLE;
            ex_fwd_sel_q  <= '0;
            stall_count_q <= '0;
        end else begin
            sb_q          <= sb_d;
            ex_fwd_sel_q  <= ex_fwd_sel_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed pipeline scenarios with literal
// expectations, then random traffic checked against a queue-based model.
module tb_fwd_hazard_unit;

    localparam int NUM_SRC    = 3;
    localparam int DEPTH      = 3;
    localparam int REG_AW     = 5;
    localparam int LOAD_READY = 2;
    localparam int SELW       = $clog2(DEPTH + 1);

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src_addr;
    logic [NUM_SRC-1:0]        id_src_used;
    logic [REG_AW-1:0]         id_dst_addr;
    logic                      id_regwr;
    logic                      id_is_load;
    logic                      id_is_branch;
    logic                      ext_stall;
    logic                      flush;
    logic                      stall_req;
    logic [NUM_SRC*SELW-1:0]   ex_fwd_sel;
    logic [NUM_SRC*SELW-1:0]   id_cmp_sel;
    logic [31:0]               stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .REG_AW(REG_AW),
        .LOAD_READY(LOAD_READY), .SELW(SELW)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_src_addr(id_src_addr), .id_src_used(id_src_used),
        .id_dst_addr(id_dst_addr), .id_regwr(id_regwr),
        .id_is_load(id_is_load), .id_is_branch(id_is_branch),
        .ext_stall(ext_stall), .flush(flush), .stall_req(stall_req),
        .ex_fwd_sel(ex_fwd_sel), .id_cmp_sel(id_cmp_sel),
        .stall_count(stall_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mq[0] is the instruction one stage past ID, mq[DEPTH-1] the oldest.
    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit ld;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_ex  = '0;
    logic [31:0] m_cnt = '0;
    bit          started = 1'b0;

    function automatic ent_t bubble();
        ent_t e;
        e.v = 1'b0; e.rd = 0; e.wr = 1'b0; e.ld = 1'b0;
        return e;
    endfunction

    function automatic int src_of(int i);
        return int'(id_src_addr[i*REG_AW +: REG_AW]);
    endfunction

    // Distance (1-based) to the youngest in-flight writer of operand i.
    function automatic int prod_stage(int i);
        if (!id_src_used[i]) return 0;
        for (int d = 0; d < mq.size(); d++) begin
            if (mq[d].v && mq[d].wr && mq[d].rd != 0 && mq[d].rd == src_of(i))
                return d + 1;
        end
        return 0;
    endfunction

    // A result is usable in EX once the producer is past its ready stage;
    // a branch wants it one cycle earlier.
    function automatic bit m_stall();
        bit hz;
        int j;
        int lat;
        hz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            j = prod_stage(i);
            if (j != 0) begin
                lat = (mq[j-1].ld ? LOAD_READY : 1) + (id_is_branch ? 1 : 0);
                if (j < lat) hz = 1'b1;
            end
        end
        return id_valid && !flush && hz;
    endfunction

    function automatic logic [NUM_SRC*SELW-1:0] m_cmp();
        logic [NUM_SRC*SELW-1:0] v;
        int j;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            j = prod_stage(i);
            v[i*SELW +: SELW] = (j == 0) ? SELW'(0) : SELW'(j - 1);
        end
        return v;
    endfunction

    function automatic logic [NUM_SRC*SELW-1:0] m_ex_next();
        logic [NUM_SRC*SELW-1:0] v;
        int j;
        v = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            j = prod_stage(i);
            v[i*SELW +: SELW] = (j >= 1 && j < DEPTH) ? SELW'(j) : SELW'(0);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq = {};
            for (int k = 0; k < DEPTH; k++) mq.push_back(bubble());
            m_ex    = '0;
            m_cnt   = '0;
            started = 1'b1;
        end else if (started && !ext_stall) begin
            bit st;
            logic [NUM_SRC*SELW-1:0] exn;
            ent_t e;
            st  = m_stall();
            exn = m_ex_next();
            if (flush || st) begin
                e = bubble();
                m_ex = '0;
            end else begin
                e.v = id_valid; e.rd = int'(id_dst_addr);
                e.wr = id_regwr; e.ld = id_is_load;
                m_ex = exn;
            end
            mq.push_front(e);
            mq = mq[0:DEPTH-1];
            if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
    end

    // Compare process: all outputs against the model, away from the edge.
    always @(negedge clk) begin
        if (started) begin
            chk("model_stall_req", 64'(stall_req), 64'(m_stall()));
            chk("model_id_cmp_sel", 64'(id_cmp_sel), 64'(m_cmp()));
            chk("model_ex_fwd_sel", 64'(ex_fwd_sel), 64'(m_ex));
            chk("model_stall_count", 64'(stall_count), 64'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input bit v, input int s0, input int s1, input int s2,
                          input logic [2:0] used, input int dst, input bit wr,
                          input bit ld, input bit br);
        id_valid     = v;
        id_src_addr  = {REG_AW'(s2), REG_AW'(s1), REG_AW'(s0)};
        id_src_used  = used;
        id_dst_addr  = REG_AW'(dst);
        id_regwr     = wr;
        id_is_load   = ld;
        id_is_branch = br;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 0, 0, 0, 3'b000, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int sel_of(logic [NUM_SRC*SELW-1:0] v, int i);
        return int'(v[i*SELW +: SELW]);
    endfunction

    initial begin
        reset = 1'b1; ext_stall = 1'b0; flush = 1'b0;
        nop();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("reset_ex_fwd_sel", 64'(ex_fwd_sel), 64'd0);
        chk("reset_stall_count", 64'(stall_count), 64'd0);
        chk("reset_stall_req", 64'(stall_req), 64'd0);

        // ALU producer at distance 1, 2, 3
        set_id(1, 1, 2, 0, 3'b011, 3, 1, 0, 0); tick();
        set_id(1, 3, 5, 0, 3'b011, 4, 1, 0, 0);
        chk("alu_b2b_no_stall", 64'(stall_req), 64'd0);
        tick();
        chk("alu_b2b_ex_sel0", 64'(sel_of(ex_fwd_sel, 0)), 64'd1);
        set_id(1, 1, 2, 0, 3'b011, 8, 1, 0, 0); tick();
        nop(); tick();
        set_id(1, 8, 0, 0, 3'b001, 9, 1, 0, 0); tick();
        chk("alu_gap1_ex_sel0", 64'(sel_of(ex_fwd_sel, 0)), 64'd2);
        set_id(1, 1, 2, 0, 3'b011, 10, 1, 0, 0); tick();
        nop(); tick();
        nop(); tick();
        set_id(1, 10, 0, 0, 3'b001, 11, 1, 0, 0); tick();
        chk("alu_gap2_ex_sel0", 64'(sel_of(ex_fwd_sel, 0)), 64'd0);

        // load-use: one stall
        set_id(1, 1, 0, 0, 3'b001, 2, 1, 1, 0); tick();
        set_id(1, 2, 2, 0, 3'b011, 6, 1, 0, 0);
        chk("lduse_stall", 64'(stall_req), 64'd1);
        tick();
        chk("lduse_stall_done", 64'(stall_req), 64'd0);
        chk("lduse_count", 64'(stall_count), 64'd1);
        tick();
        chk("lduse_ex_sel0", 64'(sel_of(ex_fwd_sel, 0)), 64'd2);
        chk("lduse_ex_sel1", 64'(sel_of(ex_fwd_sel, 1)), 64'd2);

        // branch after load: two stalls; branch after ALU: one stall
        set_id(1, 1, 0, 0, 3'b001, 2, 1, 1, 0); tick();
        set_id(1, 2, 7, 0, 3'b011, 0, 0, 0, 1);
        chk("ldbr_stall1", 64'(stall_req), 64'd1);
        tick();
        chk("ldbr_stall2", 64'(stall_req), 64'd1);
        tick();
        chk("ldbr_release", 64'(stall_req), 64'd0);
        chk("ldbr_cmp_sel0", 64'(sel_of(id_cmp_sel, 0)), 64'd2);
        tick();
        set_id(1, 1, 0, 0, 3'b001, 10, 1, 0, 0); tick();
        set_id(1, 10, 0, 0, 3'b011, 0, 0, 0, 1);
        chk("alubr_stall", 64'(stall_req), 64'd1);
        tick();
        chk("alubr_release", 64'(stall_req), 64'd0);
        chk("alubr_cmp_sel0", 64'(sel_of(id_cmp_sel, 0)), 64'd1);
        chk("alubr_count", 64'(stall_count), 64'd4);
        tick();

        // $0 producer and unused operand never match
        set_id(1, 1, 0, 0, 3'b001, 0, 1, 0, 0); tick();
        set_id(1, 0, 0, 0, 3'b011, 12, 1, 0, 0);
        chk("r0_no_stall", 64'(stall_req), 64'd0);
        chk("r0_cmp_sel", 64'(id_cmp_sel), 64'd0);
        tick();
        chk("r0_ex_sel", 64'(ex_fwd_sel), 64'd0);
        set_id(1, 1, 0, 0, 3'b001, 11, 1, 1, 0); tick();
        set_id(1, 11, 11, 11, 3'b000, 13, 1, 0, 0);
        chk("unused_no_stall", 64'(stall_req), 64'd0);
        tick();
        chk("unused_ex_sel", 64'(ex_fwd_sel), 64'd0);

        // load-use frozen by ext_stall, then flushed
        set_id(1, 1, 0, 0, 3'b001, 12, 1, 1, 0); tick();
        set_id(1, 12, 0, 0, 3'b001, 14, 1, 0, 0);
        chk("ext_stall_pre", 64'(stall_req), 64'd1);
        ext_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ext_stall_hold_req", 64'(stall_req), 64'd1);
            chk("ext_stall_hold_count", 64'(stall_count), 64'd4);
        end
        ext_stall = 1'b0; flush = 1'b1; #1;
        chk("flush_kills_stall", 64'(stall_req), 64'd0);
        tick();
        chk("flush_ex_sel", 64'(ex_fwd_sel), 64'd0);
        chk("flush_count", 64'(stall_count), 64'd4);
        flush = 1'b0;
        nop(); tick();

        // reset in the middle of a branch-after-load stall
        set_id(1, 1, 0, 0, 3'b001, 13, 1, 1, 0); tick();
        set_id(1, 13, 0, 0, 3'b001, 0, 0, 0, 1); tick();
        chk("pre_reset_stall", 64'(stall_req), 64'd1);
        chk("pre_reset_count", 64'(stall_count), 64'd5);
        reset = 1'b1; tick();
        reset = 1'b0; #1;
        chk("post_reset_stall", 64'(stall_req), 64'd0);
        chk("post_reset_ex", 64'(ex_fwd_sel), 64'd0);
        chk("post_reset_count", 64'(stall_count), 64'd0);
        set_id(1, 13, 0, 0, 3'b001, 15, 1, 0, 0); tick();
        chk("post_reset_dep_ex", 64'(sel_of(ex_fwd_sel, 0)), 64'd0);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            ext_stall = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            set_id(($urandom_range(0, 7) != 0),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
            tick();
        end
        reset = 1'b0; ext_stall = 1'b0; flush = 1'b0;
        nop();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
